// File: rtl/dvs_ravens_pkg.sv
// Shared definitions for the RAVENS DVS camera interface blocks.
package dvs_ravens_pkg;

   localparam int unsigned DVS_WIDTH_PXLS  = 346;
   localparam int unsigned DVS_HEIGHT_PXLS = 260;
   localparam int unsigned CLK_PERIOD_NS   = 10;

   // Packed on-chip event: {polarity, x, y}
   localparam int unsigned EVENT_BITS = 19;
   localparam int unsigned EV_POL_BIT = 18;
   localparam int unsigned EV_X_MSB   = 17;
   localparam int unsigned EV_X_LSB   = 9;
   localparam int unsigned EV_Y_MSB   = 8;
   localparam int unsigned EV_Y_LSB   = 0;

   localparam int unsigned COORD_BITS = 9;
   localparam int unsigned AER_BITS   = 10;

   // AER transmitter handshake sequencer
   typedef enum logic [2:0] {
      IDLE,
      Y_SETUP,
      Y_REQ,
      Y_REL,
      X_SETUP,
      X_REQ,
      X_REL,
      GAP
   } aer_tx_state_t;

endpackage

// File: rtl/dvs_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level, async reset to 0.
module dvs_sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[STAGES-2:0], d};
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dvs_event_to_aer_transmitter.sv
// Serialises packed DVS events onto the 4-phase AER bus as a Y (row) word
// followed by an X (column) word; the Y word is skipped while the row is cached.
module dvs_event_to_aer_transmitter
   import dvs_ravens_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES       = 2,
   parameter int unsigned MIN_EVENT_CYCLES   = 9,
   parameter int unsigned ROW_TIMEOUT_CYCLES = 100,
   parameter int unsigned SYNC_STAGES        = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ev_valid,
   input  logic [EVENT_BITS-1:0] ev_data,
   output logic                  ev_ready,
   output logic [AER_BITS-1:0]   aer,
   output logic                  xsel,
   output logic                  req,
   input  logic                  ack,
   output logic                  busy
);

   localparam int unsigned SETUP_W = $clog2(SETUP_CYCLES + 1);
   localparam int unsigned GAP_W   = $clog2(MIN_EVENT_CYCLES + 1);
   localparam int unsigned ROW_W   = $clog2(ROW_TIMEOUT_CYCLES + 1);

   localparam logic [SETUP_W-1:0] SETUP_MAX  = SETUP_W'(SETUP_CYCLES);
   localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
   localparam logic [GAP_W-1:0]   GAP_MAX    = GAP_W'(MIN_EVENT_CYCLES);
   localparam logic [ROW_W-1:0]   ROW_MAX    = ROW_W'(ROW_TIMEOUT_CYCLES);

   aer_tx_state_t         state, state_n;
   logic                  ev_pol, pol_n;
   logic [COORD_BITS-1:0] ev_x, x_n, ev_y, y_n, last_y, last_y_n;
   logic                  row_valid, row_valid_n;
   logic [SETUP_W-1:0]    setup_cnt, setup_n;
   logic [GAP_W-1:0]      gap_cnt, gap_n;
   logic [ROW_W-1:0]      row_cnt, row_n;
   logic [AER_BITS-1:0]   aer_n;
   logic                  xsel_n, req_n, busy_n, ev_ready_n;
   logic                  ack_s, accept;

   dvs_sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack),
      .q   (ack_s)
   );

   assign accept = ev_valid && ev_ready;

   // Next-state, next-output and counter update logic
   always_comb begin
      state_n     = state;
      pol_n       = ev_pol;
      x_n         = ev_x;
      y_n         = ev_y;
      last_y_n    = last_y;
      row_valid_n = row_valid;
      setup_n     = setup_cnt;
      aer_n       = aer;
      xsel_n      = xsel;
      req_n       = req;
      busy_n      = busy;

      gap_n = (gap_cnt < GAP_MAX) ? gap_cnt + GAP_W'(1) : gap_cnt;
      row_n = row_cnt;
      if (state == IDLE) begin
         if (row_cnt < ROW_MAX) row_n = row_cnt + ROW_W'(1);
         if (row_n == ROW_MAX)  row_valid_n = 1'b0;
      end

      unique case (state)
         IDLE: begin
            if (accept) begin
               // Accept overrides a same-edge row timeout: the hit test uses the
               // registered row_valid and the pending invalidation is dropped.
               pol_n       = ev_data[EV_POL_BIT];
               x_n         = ev_data[EV_X_MSB:EV_X_LSB];
               y_n         = ev_data[EV_Y_MSB:EV_Y_LSB];
               gap_n       = '0;
               row_n       = '0;
               row_valid_n = row_valid;
               setup_n     = '0;
               busy_n      = 1'b1;
               if (row_valid && (ev_data[EV_Y_MSB:EV_Y_LSB] == last_y)) begin
                  state_n = X_SETUP;
                  aer_n   = {ev_data[EV_X_MSB:EV_X_LSB], ev_data[EV_POL_BIT]};
                  xsel_n  = 1'b1;
               end else begin
                  state_n = Y_SETUP;
                  aer_n   = {ev_data[EV_POL_BIT], ev_data[EV_Y_MSB:EV_Y_LSB]};
                  xsel_n  = 1'b0;
               end
            end
         end
         Y_SETUP, X_SETUP: begin
            if (setup_cnt < SETUP_MAX) setup_n = setup_cnt + SETUP_W'(1);
            if ((setup_cnt >= SETUP_LAST) && !ack_s) begin
               req_n   = 1'b1;
               state_n = (state == Y_SETUP) ? Y_REQ : X_REQ;
            end
         end
         Y_REQ: begin
            if (ack_s) begin
               req_n   = 1'b0;
               state_n = Y_REL;
            end
         end
         X_REQ: begin
            if (ack_s) begin
               req_n   = 1'b0;
               state_n = X_REL;
            end
         end
         Y_REL: begin
            if (!ack_s) begin
               state_n     = X_SETUP;
               last_y_n    = ev_y;
               row_valid_n = 1'b1;
               setup_n     = '0;
               aer_n       = {ev_x, ev_pol};
               xsel_n      = 1'b1;
            end
         end
         X_REL: begin
            if (!ack_s) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase

      ev_ready_n = (state_n == IDLE) && (gap_n >= GAP_MAX);
   end

   // State, event latch, row cache, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ev_pol    <= 1'b0;
         ev_x      <= '0;
         ev_y      <= '0;
         last_y    <= '0;
         row_valid <= 1'b0;
         setup_cnt <= '0;
         gap_cnt   <= '0;
         row_cnt   <= '0;
         aer       <= '0;
         xsel      <= 1'b0;
         req       <= 1'b0;
         busy      <= 1'b0;
         ev_ready  <= 1'b0;
      end else begin
         state     <= state_n;
         ev_pol    <= pol_n;
         ev_x      <= x_n;
         ev_y      <= y_n;
         last_y    <= last_y_n;
         row_valid <= row_valid_n;
         setup_cnt <= setup_n;
         gap_cnt   <= gap_n;
         row_cnt   <= row_n;
         aer       <= aer_n;
         xsel      <= xsel_n;
         req       <= req_n;
         busy      <= busy_n;
         ev_ready  <= ev_ready_n;
      end
   end

endmodule
